mem_writeback: RTL and testbench

- Final pipeline stage of the RV64 integer core: memory-access plus write-back.
- Consumes execute-stage results tagged with rd, funct3, write_back and mem_acc.
- For ALU ops, forwards the result unchanged. For loads, runs a req/ack read on a 64-bit aligned data port, then extracts and extends the addressed byte, half, word or double.
- Drives the wb_rd / wb_value / wb_en triple that the decode stage uses to update its register file.

---
 rtl/mem_writeback.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_writeback.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_writeback.sv
// Memory-access / write-back stage of the RV64 integer core.
// ALU results pass straight through; loads run a req/ack doubleword read, then extract and extend the addressed data.
module mem_writeback #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 16
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [4:0]      in_rd,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_result,
    input  logic            in_write_back,
    input  logic            in_mem_acc,
    output logic            busy,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_value,
    output logic            wb_en,
    output logic            load_fault
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [4:0]        rd_q, rd_d;
    logic [2:0]        f3_q, f3_d;
    logic [2:0]        off_q, off_d;
    logic              wbk_q, wbk_d;
    logic              busy_q, busy_d;
    logic              mem_req_q, mem_req_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_value_q, wb_value_d;
    logic              wb_en_q, wb_en_d;
    logic              load_fault_q, load_fault_d;
    logic              load_bad_s;
    logic              timeout_s;

    // Illegal width (funct3=111) or an offset not aligned to the access size.
    function automatic logic load_is_bad(input logic [2:0] f3, input logic [2:0] off);
        logic bad;
        case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = (off[0] != 1'b0);
            3'b010, 3'b110: bad = (off[1:0] != 2'b00);
            3'b011:         bad = (off != 3'b000);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend to XLEN.
    function automatic logic [XLEN-1:0] extract(input logic [2:0] f3, input logic [2:0] off,
                                                input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] lane;
        logic [XLEN-1:0] res;
        lane = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  res = {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b001:  res = {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b010:  res = {{(XLEN-32){lane[31]}}, lane[31:0]};
            3'b011:  res = lane;
            3'b100:  res = {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b101:  res = {{(XLEN-16){1'b0}}, lane[15:0]};
            3'b110:  res = {{(XLEN-32){1'b0}}, lane[31:0]};
            default: res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    assign load_bad_s = load_is_bad(in_funct3, in_result[2:0]);
    assign timeout_s  = (cnt_q == CNT_LAST);

    // FSM state register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; ack takes priority over expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_mem_acc && !load_bad_s) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_ack || timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next-state logic; strobes default low every cycle.
    always_comb begin
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        f3_d         = f3_q;
        off_d        = off_q;
        wbk_d        = wbk_q;
        busy_d       = busy_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        wb_rd_d      = wb_rd_q;
        wb_value_d   = wb_value_q;
        wb_en_d      = 1'b0;
        load_fault_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
                if (in_valid && !in_mem_acc) begin
                    if (in_write_back && (in_rd != 5'd0)) begin
                        wb_en_d    = 1'b1;
                        wb_rd_d    = in_rd;
                        wb_value_d = in_result;
                    end else begin
                        wb_en_d = 1'b0;
                    end
                end else if (in_valid && in_mem_acc) begin
                    if (load_bad_s) begin
                        load_fault_d = 1'b1;
                    end else begin
                        rd_d       = in_rd;
                        f3_d       = in_funct3;
                        off_d      = in_result[2:0];
                        wbk_d      = in_write_back;
                        mem_req_d  = 1'b1;
                        busy_d     = 1'b1;
                        mem_addr_d = {in_result[XLEN-1:3], 3'b000};
                        cnt_d      = 8'd0;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    busy_d    = 1'b0;
                    cnt_d     = 8'd0;
                    if (wbk_q && (rd_q != 5'd0)) begin
                        wb_en_d    = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_value_d = extract(f3_q, off_q, mem_rdata);
                    end else begin
                        wb_en_d = 1'b0;
                    end
                end else if (timeout_s) begin
                    mem_req_d    = 1'b0;
                    busy_d       = 1'b0;
                    load_fault_d = 1'b1;
                    cnt_d        = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and load context.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt_q        <= 8'd0;
            rd_q         <= 5'd0;
            f3_q         <= 3'd0;
            off_q        <= 3'd0;
            wbk_q        <= 1'b0;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= {XLEN{1'b0}};
            wb_rd_q      <= 5'd0;
            wb_value_q   <= {XLEN{1'b0}};
            wb_en_q      <= 1'b0;
            load_fault_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            wbk_q        <= wbk_d;
            busy_q       <= busy_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            wb_rd_q      <= wb_rd_d;
            wb_value_q   <= wb_value_d;
            wb_en_q      <= wb_en_d;
            load_fault_q <= load_fault_d;
        end
    end

    assign busy       = busy_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign wb_rd      = wb_rd_q;
    assign wb_value   = wb_value_q;
    assign wb_en      = wb_en_q;
    assign load_fault = load_fault_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Scoreboard bench for mem_writeback: expected strobes are queued at issue and
// popped whenever the DUT pulses wb_en or load_fault.
module tb_mem_writeback;

    logic        CLK;
    logic        reset;
    logic        in_valid;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [63:0] in_result;
    logic        in_write_back;
    logic        in_mem_acc;
    logic        busy;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic [4:0]  wb_rd;
    logic [63:0] wb_value;
    logic        wb_en;
    logic        load_fault;

    typedef struct packed {
        logic        flt;
        logic [4:0]  rd;
        logic [63:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks_r = 0;
    int   errors_r = 0;

    mem_writeback #(.XLEN(64), .TIMEOUT(16)) dut (
        .CLK(CLK), .reset(reset),
        .in_valid(in_valid), .in_rd(in_rd), .in_funct3(in_funct3),
        .in_result(in_result), .in_write_back(in_write_back), .in_mem_acc(in_mem_acc),
        .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_rd(wb_rd), .wb_value(wb_value), .wb_en(wb_en), .load_fault(load_fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (reset && (wb_en || load_fault)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", {62'd0, wb_en, load_fault}, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("strobe_kind", {62'd0, wb_en, load_fault}, {62'd0, !e.flt, e.flt});
                if (!e.flt) begin
                    chk("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
                    chk("wb_value", wb_value, e.val);
                end
            end
        end
    end

    // Issue ALU ops on consecutive cycles.
    task automatic alu_op(input logic [4:0] rd, input logic [63:0] val, input logic wb);
        in_valid = 1'b1; in_mem_acc = 1'b0; in_rd = rd; in_result = val;
        in_write_back = wb; in_funct3 = 3'b000;
        if (wb && rd != 5'd0) sb_q.push_back('{flt: 1'b0, rd: rd, val: val});
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    // Issue a load; ack_at = mem_req cycle carrying ack (0 = never).
    task automatic load_op(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rdata, input int ack_at, input logic [4:0] rd,
                           input logic wb, input logic exp_fault, input logic [63:0] exp_val,
                           input int exp_req_cycles);
        int n;
        in_valid = 1'b1; in_mem_acc = 1'b1; in_rd = rd; in_result = addr;
        in_write_back = wb; in_funct3 = f3;
        if (exp_fault || ack_at == 0) sb_q.push_back('{flt: 1'b1, rd: 5'd0, val: 64'd0});
        else if (wb && rd != 5'd0) sb_q.push_back('{flt: 1'b0, rd: rd, val: exp_val});
        @(posedge CLK); #1;
        in_valid = 1'b0;
        n = 0;
        @(negedge CLK);
        if (exp_req_cycles > 0) begin
            chk({tag, "_addr"}, mem_addr, {addr[63:3], 3'b000});
            chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        end
        while (mem_req && n < 40) begin
            n++;
            chk({tag, "_addr_hold"}, mem_addr, {addr[63:3], 3'b000});
            if (n == ack_at) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end
            @(posedge CLK); #1;
            mem_ack = 1'b0;
            @(negedge CLK);
        end
        chk({tag, "_req_cycles"}, 64'(n), 64'(exp_req_cycles));
        chk({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
        @(posedge CLK); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_rd = 5'd0; in_funct3 = 3'd0; in_result = 64'd0;
        in_write_back = 1'b0; in_mem_acc = 1'b0; mem_ack = 1'b0; mem_rdata = 64'd0;
        #12;
        chk("rst_outputs", {busy, mem_req, wb_en, load_fault}, 4'b0000);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_wbval", wb_value, 64'd0);
        chk("rst_wbrd", {59'd0, wb_rd}, 64'd0);
        @(posedge CLK); #1;
        reset = 1'b1;
        @(posedge CLK); #1;

        // ALU: single, rd=0, write_back=0, then back-to-back.
        alu_op(5'd5, 64'h1234, 1'b1);
        @(negedge CLK); chk("alu_busy", {63'd0, busy}, 64'd0);
        @(posedge CLK); #1;
        alu_op(5'd0, 64'h5555, 1'b1);
        alu_op(5'd6, 64'h7777, 1'b0);
        alu_op(5'd1, 64'hAAAA_0000_0000_0001, 1'b1);
        alu_op(5'd2, 64'h0000_0000_0000_0002, 1'b1);
        alu_op(5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        @(posedge CLK); #1;

        // Loads with extraction.
        load_op("lb",  3'b000, 64'h1003, 64'h0000_0000_8000_0000, 3, 5'd10, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 3);
        load_op("lwu", 3'b110, 64'h2004, 64'hDEAD_BEEF_0000_0000, 1, 5'd11, 1'b1, 1'b0, 64'h0000_0000_DEAD_BEEF, 1);
        load_op("ld",  3'b011, 64'h2000, 64'h0123_4567_89AB_CDEF, 2, 5'd12, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 2);
        load_op("lh",  3'b001, 64'h3002, 64'h0000_0000_8001_0000, 1, 5'd13, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 1);
        load_op("lhu", 3'b101, 64'h3006, 64'h1234_0000_0000_0000, 2, 5'd14, 1'b1, 1'b0, 64'h0000_0000_0000_1234, 2);
        load_op("lbu", 3'b100, 64'h1007, 64'hAB00_0000_0000_0000, 1, 5'd15, 1'b1, 1'b0, 64'h0000_0000_0000_00AB, 1);
        load_op("lw",  3'b010, 64'h4004, 64'h8000_0000_0000_0000, 2, 5'd16, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 2);
        load_op("ld_rd0", 3'b011, 64'h4008, 64'h1111_1111_1111_1111, 1, 5'd0, 1'b1, 1'b0, 64'd0, 1);

        // Misaligned and illegal loads: fault, no request.
        load_op("lh_mis", 3'b001, 64'h3001, 64'd0, 1, 5'd3, 1'b1, 1'b1, 64'd0, 0);
        load_op("f3_111", 3'b111, 64'h3000, 64'd0, 1, 5'd3, 1'b1, 1'b1, 64'd0, 0);
        load_op("lw_mis", 3'b010, 64'h3006, 64'd0, 1, 5'd3, 1'b1, 1'b1, 64'd0, 0);
        load_op("ld_mis", 3'b011, 64'h3004, 64'd0, 1, 5'd3, 1'b1, 1'b1, 64'd0, 0);

        // Timeout, then ack on the final cycle.
        load_op("tmo", 3'b011, 64'h5000, 64'd0, 0, 5'd20, 1'b1, 1'b0, 64'd0, 16);
        load_op("ack16", 3'b011, 64'h5008, 64'hCAFE_F00D_1234_5678, 16, 5'd21, 1'b1, 1'b0, 64'hCAFE_F00D_1234_5678, 16);

        // mem_ack while idle is ignored.
        mem_ack = 1'b1; mem_rdata = 64'hFFFF;
        @(posedge CLK); #1; mem_ack = 1'b0;
        @(negedge CLK); chk("idle_ack_req", {62'd0, mem_req, busy}, 64'd0);
        @(posedge CLK); #1;

        // Reset two cycles into ACCESS.
        in_valid = 1'b1; in_mem_acc = 1'b1; in_funct3 = 3'b011; in_result = 64'h6000;
        in_rd = 5'd9; in_write_back = 1'b1;
        @(posedge CLK); #1; in_valid = 1'b0;
        @(negedge CLK); @(negedge CLK);
        chk("pre_rst_req", {63'd0, mem_req}, 64'd1);
        reset = 1'b0; #1;
        chk("mid_rst_outputs", {61'd0, mem_req, busy, wb_en}, 64'd0);
        @(posedge CLK); #1; reset = 1'b1;
        @(negedge CLK); chk("post_rst_idle", {62'd0, mem_req, load_fault}, 64'd0);
        @(posedge CLK); #1;
        alu_op(5'd7, 64'h0BAD_F00D, 1'b1);
        load_op("post_rst_ld", 3'b000, 64'h7001, 64'h0000_0000_0000_7F00, 2, 5'd8, 1'b1, 1'b0, 64'h0000_0000_0000_007F, 2);
        repeat (3) @(posedge CLK);
        #1;
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
